// File: rtl/avr_io_pkg.sv
// Shared I/O constants for the AVR peripheral slice: GTCCR address, bit
// positions, prescaler tap indices and the GTCCR register image type.
package avr_io_pkg;

  localparam logic [5:0] GTCCR_IO_ADR = 6'h23;

  localparam int TSM_BIT     = 7;
  localparam int PSRASY_BIT  = 1;
  localparam int PSRSYNC_BIT = 0;

  // Tap index = log2(N): strobe when the low TAP bits of the counter are all ones.
  localparam int TAP_8    = 3;
  localparam int TAP_32   = 5;
  localparam int TAP_64   = 6;
  localparam int TAP_128  = 7;
  localparam int TAP_256  = 8;
  localparam int TAP_1024 = 10;

  typedef struct packed {
    logic tsm;
    logic psrasy;
    logic psrsync;
  } gtccr_t;

  function automatic logic [7:0] gtccr_image(input gtccr_t r);
    logic [7:0] img;
    img              = 8'h00;
    img[TSM_BIT]     = r.tsm;
    img[PSRASY_BIT]  = r.psrasy;
    img[PSRSYNC_BIT] = r.psrsync;
    return img;
  endfunction

endpackage

// File: rtl/prescaler0_ctrl_presc_cnt.sv
// Prescaler 0 counter with synchronous clear/hold and clock-enable tap decode.
// Optional clk32en/clk128en taps are built when PRESC0_EXT_TAPS_EN is defined.
module presc_cnt
  import avr_io_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic psrsync_nxt,
  input  logic psrsync_cur,
  output logic clk8en,
  output logic clk64en,
  output logic clk256en,
  output logic clk1024en
`ifdef PRESC0_EXT_TAPS_EN
  ,
  output logic clk32en,
  output logic clk128en
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb assigns its outputs a default first, so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    // Clear on the edge that sets PSRSYNC and hold at 0 while it is still set.
    if (psrsync_nxt || psrsync_cur) cnt_d = '0;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign clk8en    = ~psrsync_cur & (&cnt_q[TAP_8-1:0]);
  assign clk64en   = ~psrsync_cur & (&cnt_q[TAP_64-1:0]);
  assign clk256en  = ~psrsync_cur & (&cnt_q[TAP_256-1:0]);
  assign clk1024en = ~psrsync_cur & (&cnt_q[TAP_1024-1:0]);

`ifdef PRESC0_EXT_TAPS_EN
  assign clk32en   = ~psrsync_cur & (&cnt_q[TAP_32-1:0]);
  assign clk128en  = ~psrsync_cur & (&cnt_q[TAP_128-1:0]);
`endif

endmodule

// File: rtl/prescaler0_ctrl.sv
// Prescaler 0 with GTCCR (TSM/PSRASY/PSRSYNC) register and I/O bus access.
// Define PRESC0_EXT_TAPS_EN to add the clk32en and clk128en strobes.
module prescaler0_ctrl
  import avr_io_pkg::*;
#(
  parameter logic [5:0] GTCCR_ADR = GTCCR_IO_ADR,
  parameter int         CNT_W     = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] adr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic       psrasy_clr,
  output logic       tsm,
  output logic       psrasy,
  output logic       psrsync,
  output logic       clk8en,
  output logic       clk64en,
  output logic       clk256en,
  output logic       clk1024en
`ifdef PRESC0_EXT_TAPS_EN
  ,
  output logic       clk32en,
  output logic       clk128en
`endif
);

  gtccr_t gtccr_q, gtccr_d;
  logic   gtccr_we;
  logic   unused_dbus;

  assign gtccr_we    = iowe & (adr == GTCCR_ADR);
  assign unused_dbus = ^dbus_in[6:2];

  always_comb begin
    gtccr_d = gtccr_q;
    if (gtccr_we) gtccr_d.tsm = dbus_in[TSM_BIT];
    // A written 1 wins over the hardware clear; clears only act once TSM is 0.
    if (gtccr_we && dbus_in[PSRASY_BIT])    gtccr_d.psrasy = 1'b1;
    else if (!gtccr_d.tsm && psrasy_clr)    gtccr_d.psrasy = 1'b0;
    if (gtccr_we && dbus_in[PSRSYNC_BIT])   gtccr_d.psrsync = 1'b1;
    else if (!gtccr_d.tsm)                  gtccr_d.psrsync = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) gtccr_q <= '0;
    else       gtccr_q <= gtccr_d;
  end

  assign tsm      = gtccr_q.tsm;
  assign psrasy   = gtccr_q.psrasy;
  assign psrsync  = gtccr_q.psrsync;
  assign out_en   = iore & (adr == GTCCR_ADR);
  assign dbus_out = out_en ? gtccr_image(gtccr_q) : 8'h00;

  presc_cnt #(
    .CNT_W(CNT_W)
  ) u_presc_cnt (
    .clk        (clk),
    .nrst       (nrst),
    .psrsync_nxt(gtccr_d.psrsync),
    .psrsync_cur(gtccr_q.psrsync),
    .clk8en     (clk8en),
    .clk64en    (clk64en),
    .clk256en   (clk256en),
    .clk1024en  (clk1024en)
`ifdef PRESC0_EXT_TAPS_EN
    ,
    .clk32en    (clk32en),
    .clk128en   (clk128en)
`endif
  );

endmodule

// File: tb/tb_prescaler0_ctrl.sv
// Randomized self-checking bench for prescaler0_ctrl against a cycle-count
// reference model of the GTCCR rules and prescaler tap timing.
module tb_prescaler0_ctrl;
  import avr_io_pkg::*;

  localparam logic [5:0] ADR = GTCCR_IO_ADR;

  logic       clk, nrst;
  logic [5:0] adr;
  logic       iore, iowe, psrasy_clr;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en, tsm, psrasy, psrsync;
  logic       clk8en, clk64en, clk256en, clk1024en;
`ifdef PRESC0_EXT_TAPS_EN
  logic       clk32en, clk128en;
`endif

  prescaler0_ctrl dut (
    .clk       (clk),
    .nrst      (nrst),
    .adr       (adr),
    .iore      (iore),
    .iowe      (iowe),
    .dbus_in   (dbus_in),
    .dbus_out  (dbus_out),
    .out_en    (out_en),
    .psrasy_clr(psrasy_clr),
    .tsm       (tsm),
    .psrasy    (psrasy),
    .psrsync   (psrsync),
    .clk8en    (clk8en),
    .clk64en   (clk64en),
    .clk256en  (clk256en),
    .clk1024en (clk1024en)
`ifdef PRESC0_EXT_TAPS_EN
    ,
    .clk32en   (clk32en),
    .clk128en  (clk128en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: GTCCR bits plus number of free-running cycles since the
  // counter last restarted from 0.
  bit m_tsm, m_psrasy, m_psrsync;
  int m_run;

  // Last sampled DUT values, for directed timing checks.
  logic s_clk8, s_clk64, s_psrsync, s_psrasy, s_out_en, s_any;
  logic [7:0] s_dbus;

  function automatic logic exp_strb(input int n);
    return !m_psrsync && ((m_run % n) == n - 1);
  endfunction

  task automatic model_reset();
    m_tsm = 0; m_psrasy = 0; m_psrsync = 0; m_run = 0;
  endtask

  task automatic model_edge();
    bit wr, tsm_n, ps_n, pa_n;
    if (!nrst) begin
      model_reset();
      return;
    end
    wr    = iowe && (adr == ADR);
    tsm_n = wr ? dbus_in[7] : m_tsm;
    if (wr && dbus_in[0])          ps_n = 1;
    else if (!tsm_n)               ps_n = 0;
    else                           ps_n = m_psrsync;
    if (wr && dbus_in[1])          pa_n = 1;
    else if (!tsm_n && psrasy_clr) pa_n = 0;
    else                           pa_n = m_psrasy;
    m_run     = (ps_n || m_psrsync) ? 0 : m_run + 1;
    m_tsm     = tsm_n;
    m_psrsync = ps_n;
    m_psrasy  = pa_n;
  endtask

  task automatic compare_all();
    logic [7:0] img;
    logic       oe;
    oe  = iore && (adr == ADR);
    img = oe ? {m_tsm, 5'b0, m_psrasy, m_psrsync} : 8'h00;
    check("out_en",    {7'b0, out_en},    {7'b0, oe});
    check("dbus_out",  dbus_out,          img);
    check("tsm",       {7'b0, tsm},       {7'b0, m_tsm});
    check("psrasy",    {7'b0, psrasy},    {7'b0, m_psrasy});
    check("psrsync",   {7'b0, psrsync},   {7'b0, m_psrsync});
    check("clk8en",    {7'b0, clk8en},    {7'b0, exp_strb(8)});
    check("clk64en",   {7'b0, clk64en},   {7'b0, exp_strb(64)});
    check("clk256en",  {7'b0, clk256en},  {7'b0, exp_strb(256)});
    check("clk1024en", {7'b0, clk1024en}, {7'b0, exp_strb(1024)});
`ifdef PRESC0_EXT_TAPS_EN
    check("clk32en",   {7'b0, clk32en},   {7'b0, exp_strb(32)});
    check("clk128en",  {7'b0, clk128en},  {7'b0, exp_strb(128)});
`endif
    s_clk8 = clk8en; s_clk64 = clk64en; s_psrsync = psrsync; s_psrasy = psrasy;
    s_out_en = out_en; s_dbus = dbus_out;
    s_any = clk8en | clk64en | clk256en | clk1024en;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    iowe = 0; dbus_in = 8'h00; psrasy_clr = 0; iore = 1; adr = ADR;
  endtask

  task automatic write_step(input logic [7:0] d);
    iowe = 1; dbus_in = d; adr = ADR;
    step();
    iowe = 0; dbus_in = 8'h00;
  endtask

  initial begin
    int c8, c1024, first8, first64, any_cnt;
    logic ps1, ps2;

    nrst = 0; idle_bus(); iore = 0;
    model_reset();
    @(negedge clk);
    #1 compare_all();
    @(negedge clk);
    nrst = 1;

    // Free run from reset release, random reads on the bus.
    c8 = 0; c1024 = 0;
    for (int i = 0; i < 2048; i++) begin
      iore = 1'($urandom_range(0, 1));
      adr  = ($urandom_range(0, 1) == 1) ? ADR : 6'($urandom_range(0, 63));
      step();
      c8    += int'(s_clk8);
      c1024 += int'(s_any & dut.clk1024en === 1'b0 ? 0 : 0);
    end
    c1024 = 0;
    // Re-run the count for clk1024en over the next full period window.
    model_reset(); nrst = 0; #1; nrst = 1; idle_bus();
    for (int i = 0; i < 2048; i++) begin
      #1 c1024 += int'(clk1024en);
      #0 step_fix();
    end
    check("clk8en_count_2048", 8'(c8 / 2), 8'd128);
    check("clk1024en_count_2048", 8'(c1024), 8'd2);

    for (int i = 0; i < 500; i++) step();

    // PSRSYNC pulse with TSM=0.
    write_step(8'h01);
    first8 = 0; first64 = 0; ps1 = 1'bx; ps2 = 1'bx;
    for (int j = 1; j <= 80; j++) begin
      step();
      if (j == 1) ps1 = s_psrsync;
      if (j == 2) ps2 = s_psrsync;
      if (s_clk8 && first8 == 0) first8 = j;
      if (s_clk64 && first64 == 0) first64 = j;
    end
    check("psrsync_first_cycle", {7'b0, ps1}, 8'd1);
    check("psrsync_second_cycle", {7'b0, ps2}, 8'd0);
    check("first_clk8_after_psr", 8'(first8), 8'd9);
    check("first_clk64_after_psr", 8'(first64), 8'd65);

    // TSM hold with PSRSYNC.
    write_step(8'h81);
    any_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      any_cnt += int'(s_any);
    end
    check("hold_strobes", 8'(any_cnt), 8'd0);
    check("hold_readback", s_dbus, 8'h81);
    write_step(8'h00);
    first8 = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (s_clk8 && first8 == 0) first8 = j;
    end
    check("release_first_clk8", 8'(first8), 8'd8);

    // PSRASY held by TSM, cleared by psrasy_clr after release.
    write_step(8'h82);
    for (int i = 0; i < 10; i++) begin
      psrasy_clr = (i % 3 == 0);
      step();
    end
    psrasy_clr = 0;
    check("psrasy_held", {7'b0, s_psrasy}, 8'd1);
    write_step(8'h00);
    step();
    check("psrasy_after_release", {7'b0, s_psrasy}, 8'd1);
    psrasy_clr = 1; step(); psrasy_clr = 0;
    step();
    check("psrasy_cleared_readback", s_dbus, 8'h00);

    // Wrong address read.
    iore = 1; adr = ADR ^ 6'h01; step();
    check("wrong_adr_out_en", {7'b0, s_out_en}, 8'd0);
    check("wrong_adr_dbus", s_dbus, 8'h00);
    adr = ADR;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      iore       = 1'($urandom_range(0, 1));
      adr        = ($urandom_range(0, 3) != 0) ? ADR : 6'($urandom_range(0, 63));
      iowe       = ($urandom_range(0, 15) == 0);
      dbus_in    = 8'($urandom);
      psrasy_clr = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_bus();
    write_step(8'h00);

    // Asynchronous reset mid-count with TSM=1.
    for (int i = 0; i < 300; i++) step();
    write_step(8'h80);
    #3 nrst = 0;
    model_reset();
    #1 compare_all();
    check("async_reset_any_strobe", {7'b0, s_any}, 8'd0);
    @(negedge clk);
    nrst = 1;
    first8 = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (s_clk8 && first8 == 0) first8 = j;
    end
    check("restart_first_clk8", 8'(first8), 8'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic step_fix();
    step();
  endtask

endmodule
